// File: rtl/uop_exec_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uop_exec_queue
//  Description : DEPTH-entry valid/ready uop queue in front of the execute
//                datapath. The head entry is decoded into register-file, ALU,
//                flag and memory-request controls. Write and request strobes
//                are gated by go = out_valid & ~stop & ~flush.
//                Optional feature macro: UOP_EXEC_BYPASS_EN. When it is
//                defined, an empty queue forwards the incoming uop to the
//                decode outputs in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module uop_exec_queue #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 2,
  parameter  int NSCHED = 2,
  localparam int TAG_W  = (NSCHED > 1) ? $clog2(NSCHED) : 1,
  localparam int OCC_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              a_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [19:0]       in_uop,
  input  logic [DATA_W-1:0] in_temp,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              in_main,
  input  logic              stop,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] t16,
  output logic [2:0]        idx_a,
  output logic [2:0]        idx_b,
  output logic              sel_inp,
  output logic [2:0]        idx_dest,
  output logic [3:0]        alu_f,
  output logic              carry_mask,
  output logic              flags_w,
  output logic              reg_wr,
  output logic              mar_wr,
  output logic              mem_rq_width,
  output logic              mem_rq_cmd,
  output logic              mem_rq,
  output logic [TAG_W-1:0]  sched_tag,
  output logic              sched_main,
  output logic              main_ex_mem,
  output logic [OCC_W-1:0]  occupancy
);

  localparam int              PTR_W     = $clog2(DEPTH);
  localparam logic [19:0]     C_NOP_UOP = 20'h00F00;
  localparam logic [OCC_W-1:0] C_DEPTH  = OCC_W'(DEPTH);

  logic [19:0]       r_mem_uop  [DEPTH];
  logic [DATA_W-1:0] r_mem_temp [DEPTH];
  logic [TAG_W-1:0]  r_mem_tag  [DEPTH];
  logic              r_mem_main [DEPTH];

  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [OCC_W-1:0]  r_occ;

  logic              w_empty;
  logic              w_full;
  logic              w_bypass;
  logic              w_go;
  logic              w_push;
  logic              w_pop;
  logic [19:0]       w_head_uop;
  logic [DATA_W-1:0] w_head_temp;
  logic [TAG_W-1:0]  w_head_tag;
  logic              w_head_main;
  logic              w_unused_b7;

  // Occupancy alone decides full and empty, so in_ready depends only on state.
  assign w_empty  = (r_occ == '0);
  assign w_full   = (r_occ == C_DEPTH);
  assign in_ready = ~w_full;

`ifdef UOP_EXEC_BYPASS_EN
  assign w_bypass = w_empty & in_valid & ~flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign out_valid = ~w_empty | w_bypass;
  assign w_go      = out_valid & ~stop & ~flush;
  // A bypassed uop that executes immediately is never written.
  assign w_push    = in_valid & ~w_full & ~flush & ~(w_bypass & w_go);
  assign w_pop     = w_go & ~w_empty;

  // Select the head: stored entry, else bypassed input, else NOP.
  always_comb begin
    w_head_uop  = C_NOP_UOP;
    w_head_temp = '0;
    w_head_tag  = '0;
    w_head_main = 1'b0;
    if (!w_empty) begin
      w_head_uop  = r_mem_uop[r_rd_ptr];
      w_head_temp = r_mem_temp[r_rd_ptr];
      w_head_tag  = r_mem_tag[r_rd_ptr];
      w_head_main = r_mem_main[r_rd_ptr];
    end else if (w_bypass) begin
      w_head_uop  = in_uop;
      w_head_temp = in_temp;
      w_head_tag  = in_tag;
      w_head_main = in_main;
    end
  end

  // Entry storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_uop[r_wr_ptr]  <= in_uop;
      r_mem_temp[r_wr_ptr] <= in_temp;
      r_mem_tag[r_wr_ptr]  <= in_tag;
      r_mem_main[r_wr_ptr] <= in_main;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue outright.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_occ <= r_occ + OCC_W'(1);
      else if (w_pop && !w_push) r_occ <= r_occ - OCC_W'(1);
    end
  end

  // Head decode.
  assign occupancy    = r_occ;
  assign t16          = w_head_temp;
  assign idx_a        = w_head_uop[2:0];
  assign idx_b        = w_head_uop[5:3];
  assign sel_inp      = w_head_uop[6];
  assign idx_dest     = w_head_uop[10:8];
  assign alu_f        = w_head_uop[19:16];
  assign carry_mask   = ~w_head_uop[15];
  assign flags_w      = w_head_uop[12] & w_go;
  assign reg_wr       = ~w_head_uop[11] & w_go;
  assign mar_wr       = w_head_uop[11] & ~w_head_uop[10] & ~w_head_uop[9] & w_go;
  assign mem_rq_width = mar_wr & w_head_uop[8];
  assign mem_rq_cmd   = w_head_uop[13];
  assign mem_rq       = (w_head_uop[13] | w_head_uop[14]) & w_go;
  assign sched_tag    = w_head_tag;
  assign sched_main   = w_head_main;
  assign main_ex_mem  = mem_rq & w_head_main;

  // Bit 7 of the uop word carries no control in this stage.
  assign w_unused_b7  = w_head_uop[7];

endmodule
`default_nettype wire
